// File: rtl/dot_acc.sv
// dot_acc: sums every K consecutive unsigned products into one dot-product
// value and buffers completed sums in a 2-entry FIFO with valid/ready output.
// Products are accepted every cycle with no backpressure toward upstream.
// Optional feature macro: DOT_ACC_LAST_EN adds i_prod_last, which ends a
// vector before it reaches K products.
module dot_acc #(
  parameter int W = 8,
  parameter int K = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_prod_valid,
  input  logic [W-1:0]                  i_prod,
`ifdef DOT_ACC_LAST_EN
  input  logic                          i_prod_last,
`endif
  input  logic                          i_clear,
  output logic [W+$clog2(K+1)-1:0]      o_sum,
  output logic                          o_sum_valid,
  input  logic                          i_sum_ready,
  output logic                          o_acc_busy,
  output logic                          o_overflow
);

  localparam int CNT_W = $clog2(K + 1);
  localparam int ACC_W = W + CNT_W;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] q0;
  logic [ACC_W-1:0] q1;
  logic [1:0]       qn;

  logic             last_prod;
  logic             push;
  logic             pop;
  logic [ACC_W-1:0] push_sum;

  // Decide whether this edge completes a vector and whether the head is taken
  always_comb begin
    last_prod = (cnt == CNT_W'(K - 1));
`ifdef DOT_ACC_LAST_EN
    last_prod = last_prod | i_prod_last;
`endif
    push     = i_prod_valid & ~i_clear & last_prod;
    pop      = (qn != 2'd0) & i_sum_ready;
    push_sum = acc + {{CNT_W{1'b0}}, i_prod};
  end

  // Accumulator and product counter; clear has priority over a product
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (i_prod_valid) begin
      if (last_prod) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= push_sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Output queue: q0 is the registered head and keeps its value once empty.
  // A push and pop on the same edge shift q1 into the head and refill the
  // tail, so a full queue never drops in that case.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q0         <= '0;
      q1         <= '0;
      qn         <= 2'd0;
      o_overflow <= 1'b0;
    end else begin
      if (i_clear)
        o_overflow <= 1'b0;
      case ({push, pop})
        2'b11: begin
          if (qn == 2'd2) begin
            q0 <= q1;
            q1 <= push_sum;
          end else begin
            q0 <= push_sum;
          end
        end
        2'b01: begin
          if (qn == 2'd2)
            q0 <= q1;
          qn <= qn - 2'd1;
        end
        2'b10: begin
          if (qn == 2'd0) begin
            q0 <= push_sum;
            qn <= 2'd1;
          end else if (qn == 2'd1) begin
            q1 <= push_sum;
            qn <= 2'd2;
          end else begin
            o_overflow <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_sum       = q0;
  assign o_sum_valid = (qn != 2'd0);
  assign o_acc_busy  = (cnt != '0);

endmodule

// File: tb/tb_dot_acc.sv
// Directed self-checking bench for dot_acc (W=8, K=4).
module tb_dot_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pv = 1'b0;
  logic [7:0]  prod = '0;
  logic        plast = 1'b0;
  logic        clr = 1'b0;
  logic [10:0] sum;
  logic        sum_valid;
  logic        ready = 1'b0;
  logic        busy;
  logic        ovf;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dot_acc #(.W(8), .K(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_prod_valid(pv),
    .i_prod      (prod),
`ifdef DOT_ACC_LAST_EN
    .i_prod_last (plast),
`endif
    .i_clear     (clr),
    .o_sum       (sum),
    .o_sum_valid (sum_valid),
    .i_sum_ready (ready),
    .o_acc_busy  (busy),
    .o_overflow  (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] p);
    pv   = 1'b1;
    prod = p;
    tick();
    pv    = 1'b0;
    plast = 1'b0;
  endtask

  initial begin
    // reset
    tick(); tick();
    chk("rst_sum", 32'(sum), 0);
    chk("rst_valid", 32'(sum_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst = 1'b0;

    // 3+5+7+9 = 24
    ready = 1'b1;
    put(3); chk("t1_busy1", 32'(busy), 1); chk("t1_nv1", 32'(sum_valid), 0);
    put(5); chk("t1_busy2", 32'(busy), 1);
    put(7); chk("t1_busy3", 32'(busy), 1); chk("t1_nv3", 32'(sum_valid), 0);
    put(9);
    chk("t1_sum", 32'(sum), 24);
    chk("t1_valid", 32'(sum_valid), 1);
    chk("t1_busy4", 32'(busy), 0);
    tick();
    chk("t1_valid_pulse", 32'(sum_valid), 0);
    chk("t1_hold", 32'(sum), 24);

    // full-scale products, then back-to-back vector
    put(255); put(255); put(255); put(255);
    chk("t2_sum", 32'(sum), 1020);
    chk("t2_valid", 32'(sum_valid), 1);
    put(1);
    chk("t2_popped", 32'(sum_valid), 0);
    put(1); put(1); put(1);
    chk("t2_sum4", 32'(sum), 4);
    chk("t2_valid4", 32'(sum_valid), 1);
    tick();
    chk("t2_empty", 32'(sum_valid), 0);

    // overflow: 10, 20, 30 with ready low
    ready = 1'b0;
    put(1); put(2); put(3); put(4);
    chk("t3_sum10", 32'(sum), 10);
    put(2); put(4); put(6); put(8);
    chk("t3_full_head", 32'(sum), 10);
    chk("t3_no_ovf", 32'(ovf), 0);
    put(3); put(6); put(9); put(12);
    chk("t3_ovf", 32'(ovf), 1);
    chk("t3_head_kept", 32'(sum), 10);
    ready = 1'b1;
    tick();
    chk("t3_sum20", 32'(sum), 20);
    chk("t3_valid20", 32'(sum_valid), 1);
    tick();
    chk("t3_empty", 32'(sum_valid), 0);
    chk("t3_ovf_sticky", 32'(ovf), 1);
    ready = 1'b0;
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t3_ovf_clr", 32'(ovf), 0);

    // push and pop on the same edge while full
    put(1); put(2); put(3); put(4);
    chk("t4_head10", 32'(sum), 10);
    put(2); put(4); put(6); put(8);
    put(3); put(6); put(9);
    ready = 1'b1;
    put(12);
    chk("t4_head20", 32'(sum), 20);
    chk("t4_no_ovf", 32'(ovf), 0);
    ready = 1'b0;
    tick();
    chk("t4_stable", 32'(sum), 20);
    ready = 1'b1;
    tick();
    chk("t4_head30", 32'(sum), 30);
    chk("t4_valid30", 32'(sum_valid), 1);
    tick();
    chk("t4_empty", 32'(sum_valid), 0);

    // clear aborts a partial vector
    put(4); put(6);
    chk("t5_busy", 32'(busy), 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t5_busy_clr", 32'(busy), 0);
    put(1); put(2); put(3); put(4);
    chk("t5_sum", 32'(sum), 10);
    tick();
    // clear with the Kth product: no push
    put(1); put(1); put(1);
    clr = 1'b1; put(1); clr = 1'b0;
    chk("t5_kth_nopush", 32'(sum_valid), 0);
    chk("t5_kth_busy", 32'(busy), 0);

    // reset mid-vector with a queued sum
    ready = 1'b0;
    put(5); put(5); put(5); put(5);
    chk("t6_queued", 32'(sum), 20);
    put(1); put(1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_valid", 32'(sum_valid), 0);
    chk("t6_sum", 32'(sum), 0);
    chk("t6_busy", 32'(busy), 0);

`ifdef DOT_ACC_LAST_EN
    ready = 1'b1;
    put(7);
    plast = 1'b1; put(8);
    chk("t7_sum15", 32'(sum), 15);
    chk("t7_busy", 32'(busy), 0);
    put(1); put(2); put(3); put(4);
    chk("t7_sum10", 32'(sum), 10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
